cdb_arb: RTL and testbench
==========================

# cdb_arb

- Round-robin arbiter sharing the 4-lane common data bus (CDB) among NUM_REQ functional-unit completion ports.
- Each cycle it grants up to 4 pending results, packs them into the lowest CDB lanes, and registers the broadcast (valid mask plus PR/AR tags) for one cycle.
- The registered broadcast feeds the map table's cdb_broadcast / cdb_pr_tag0-3 / cdb_ar_tag0-3 inputs, the RS wakeup logic and the ROB complete logic.

## Interface
Parameters:
- NUM_REQ, 8, number of completion requesters; must be ≥ 4. Pointer width is $clog2(NUM_REQ).
- PR_W, 7, physical register tag width.
- AR_W, 5, architectural register tag width.
- `CDB_WIDTH (codebase macro), 4, number of CDB lanes.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (0 = reset).
- flush  in  1  mispredict recovery; suppresses all grants this cycle.
- req_valid  in  NUM_REQ  requester i holds a completed result.
- req_pr_tag  in  NUM_REQ*PR_W  packed; requester i at bits [i*PR_W +: PR_W].
- req_ar_tag  in  NUM_REQ*AR_W  packed; requester i at bits [i*AR_W +: AR_W].
- req_grant  out  NUM_REQ  combinational; result i is taken at this clock edge.
- cdb_broadcast  out  `CDB_WIDTH  registered lane-valid mask.
- cdb_pr_tag0..3  out  PR_W each  registered lane PR tags.
- cdb_ar_tag0..3  out  AR_W each  registered lane AR tags.
- rr_ptr  out  $clog2(NUM_REQ)  current round-robin start pointer; for debug and verification.

## Operation
- State consists of rr_ptr and the output registers. There is no other FSM.
- Scan order starts at rr_ptr and covers rr_ptr, rr_ptr+1, … modulo NUM_REQ, visiting each requester exactly once.
- The first k valid requesters in scan order are granted, where k = min(4, number valid).
  - The j-th granted requester (j = 0..k-1) is placed in lane j.
- Lane packing is always contiguous from lane 0. Legal cdb_broadcast values: 0000, 0001, 0011, 0111, 1111.
- Unused lanes drive tag 0.
- Pointer update:
  - If k > 0: rr_ptr_next = (index of the last granted requester + 1) mod NUM_REQ.
  - If k = 0: rr_ptr is held.
- flush=1:
  - req_grant = 0.
  - Next cdb_broadcast = 0 and all tags = 0.
  - rr_ptr is held.
- Handshake:
  - A requester keeps req_valid and its tags stable until it sees req_grant=1 at a posedge.
  - It may present a new result in the cycle immediately after the grant.
- req_grant depends only on req_valid, rr_ptr, flush and reset. It has no dependence on the tags.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/4) cycles (2 cycles for NUM_REQ=8), provided flush stays low.
- The block performs no duplicate-tag checking. Uniqueness of PR tags is guaranteed upstream by the free list.

## Timing
- Grant to broadcast: 1 cycle. A grant asserted in cycle n appears on the cdb_* outputs in cycle n+1, for exactly 1 cycle, unless it is re-granted.
- Reset assertion, including mid-operation:
  - cdb_broadcast, all tags and rr_ptr go to 0 immediately (asynchronous).
  - req_grant = 0 while reset=0.
  - In-flight grants are lost. Requesters are reset by the same signal.
- First grants are possible in the first cycle after reset deasserts. rr_ptr = 0 at that point.
- Wrap-around: the scan and rr_ptr_next both wrap modulo NUM_REQ. If requester NUM_REQ-1 is the last granted, rr_ptr_next = 0.
- Simultaneous flush and reset: reset wins. Outputs follow the reset values.
- When fewer than 4 requesters are valid, all valid ones are granted in the same cycle.

## Test plan
- Reset mid-stream (cdb_broadcast=1111): drop reset to 0 between edges → all cdb_* outputs 0 and rr_ptr 0 with no clock edge; req_grant=0 while reset is low.
- Single request, rr_ptr=0, req3 valid (pr=40, ar=5):
  - req_grant = 0000_1000 in the same cycle.
  - Next cycle: cdb_broadcast=0001, cdb_pr_tag0=40, cdb_ar_tag0=5, other tags 0, rr_ptr=4.
- All 8 valid with rr_ptr=0, over two cycles:
  - Cycle 1: grants req0-3; next cycle cdb_broadcast=1111 with lanes 0-3 = req0-3 tags; rr_ptr=4.
  - Cycle 2 (all still valid): grants req4-7; rr_ptr=0.
- Wrap-around: rr_ptr=6, req_valid = {0,1,2,6,7}:
  - Grants req6, req7, req0, req1.
  - Lanes 0-3 carry req6, req7, req0, req1 tags in that order.
  - rr_ptr=2; req2 is granted first in the following cycle.
- Flush: all valid, flush=1 → req_grant=0, next cdb_broadcast=0, rr_ptr unchanged.
- Idle: req_valid=0 for 3 cycles → cdb_broadcast=0 each cycle and rr_ptr held at its prior value.

Source files
------------

// File: rtl/cdb_arb.sv
// cdb_arb: round-robin arbiter packing up to four completions onto the CDB.
// Grants are combinational; the lane broadcast is registered for one cycle.
`ifndef CDB_WIDTH
`define CDB_WIDTH 4
`endif

module cdb_arb #(
    parameter int NUM_REQ = 8,
    parameter int PR_W = 7,
    parameter int AR_W = 5,
    localparam int PTR_W = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*PR_W-1:0] req_pr_tag,
    input  logic [NUM_REQ*AR_W-1:0] req_ar_tag,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [`CDB_WIDTH-1:0]   cdb_broadcast,
    output logic [PR_W-1:0]         cdb_pr_tag0,
    output logic [PR_W-1:0]         cdb_pr_tag1,
    output logic [PR_W-1:0]         cdb_pr_tag2,
    output logic [PR_W-1:0]         cdb_pr_tag3,
    output logic [AR_W-1:0]         cdb_ar_tag0,
    output logic [AR_W-1:0]         cdb_ar_tag1,
    output logic [AR_W-1:0]         cdb_ar_tag2,
    output logic [AR_W-1:0]         cdb_ar_tag3,
    output logic [PTR_W-1:0]        rr_ptr
);

    localparam int LANES  = `CDB_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(LANES + 1);

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] cnt;
    logic [LANES-1:0] lane_vld;
    logic [PR_W-1:0]  lane_pr [LANES];
    logic [AR_W-1:0]  lane_ar [LANES];
    logic [PR_W-1:0]  bc_pr [LANES];
    logic [AR_W-1:0]  bc_ar [LANES];

    // Walk requesters from rr_ptr; each hit fills the next free lane.
    always_comb begin
        req_grant = '0;
        lane_vld  = '0;
        cnt       = '0;
        idx       = '0;
        last      = rr_ptr;
        for (int l = 0; l < LANES; l++) begin
            lane_pr[l] = '0;
            lane_ar[l] = '0;
        end
        if (reset && !flush) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (int'(rr_ptr) + j >= NUM_REQ)
                    idx = PTR_W'(int'(rr_ptr) + j - NUM_REQ);
                else
                    idx = PTR_W'(int'(rr_ptr) + j);
                if (req_valid[idx] && cnt < CNT_W'(LANES)) begin
                    req_grant[idx] = 1'b1;
                    lane_vld[cnt[LANE_W-1:0]] = 1'b1;
                    lane_pr[cnt[LANE_W-1:0]] = req_pr_tag[idx*PR_W +: PR_W];
                    lane_ar[cnt[LANE_W-1:0]] = req_ar_tag[idx*AR_W +: AR_W];
                    last = idx;
                    cnt  = cnt + CNT_W'(1);
                end
            end
        end
        if (cnt == '0)
            ptr_next = rr_ptr;
        else if (last == PTR_W'(NUM_REQ - 1))
            ptr_next = '0;
        else
            ptr_next = last + PTR_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr        <= '0;
            cdb_broadcast <= '0;
            for (int l = 0; l < LANES; l++) begin
                bc_pr[l] <= '0;
                bc_ar[l] <= '0;
            end
        end else begin
            rr_ptr        <= ptr_next;
            cdb_broadcast <= lane_vld;
            for (int l = 0; l < LANES; l++) begin
                bc_pr[l] <= lane_pr[l];
                bc_ar[l] <= lane_ar[l];
            end
        end
    end

    assign cdb_pr_tag0 = bc_pr[0];
    assign cdb_pr_tag1 = bc_pr[1];
    assign cdb_pr_tag2 = bc_pr[2];
    assign cdb_pr_tag3 = bc_pr[3];
    assign cdb_ar_tag0 = bc_ar[0];
    assign cdb_ar_tag1 = bc_ar[1];
    assign cdb_ar_tag2 = bc_ar[2];
    assign cdb_ar_tag3 = bc_ar[3];

endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: directed vector table, reset corner cases and a
// randomized run against a queue-based round-robin model.
module tb_cdb_arb;

    localparam int N = 8;
    localparam int PR_W = 7;
    localparam int AR_W = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*PR_W-1:0] req_pr_tag;
    logic [N*AR_W-1:0] req_ar_tag;
    logic [N-1:0] req_grant;
    logic [3:0] cdb_broadcast;
    logic [PR_W-1:0] pr0, pr1, pr2, pr3;
    logic [AR_W-1:0] ar0, ar1, ar2, ar3;
    logic [2:0] rr_ptr;

    logic [PR_W-1:0] tpr [N];
    logic [AR_W-1:0] tar [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_pr_tag[i*PR_W +: PR_W] = tpr[i];
            req_ar_tag[i*AR_W +: AR_W] = tar[i];
        end
    end

    cdb_arb #(.NUM_REQ(N), .PR_W(PR_W), .AR_W(AR_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid),
        .req_pr_tag(req_pr_tag), .req_ar_tag(req_ar_tag),
        .req_grant(req_grant), .cdb_broadcast(cdb_broadcast),
        .cdb_pr_tag0(pr0), .cdb_pr_tag1(pr1),
        .cdb_pr_tag2(pr2), .cdb_pr_tag3(pr3),
        .cdb_ar_tag0(ar0), .cdb_ar_tag1(ar1),
        .cdb_ar_tag2(ar2), .cdb_ar_tag3(ar3),
        .rr_ptr(rr_ptr)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0]      valid;
        logic            flush;
        logic [7:0]      grant;
        logic [3:0]      bc;
        logic [3:0][3:0] lanes;
        logic [2:0]      ptr;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] v, input logic f,
                                input logic [7:0] g, input logic [3:0] b,
                                input int l0, input int l1,
                                input int l2, input int l3,
                                input int p);
        vec_t r;
        r.valid = v;
        r.flush = f;
        r.grant = g;
        r.bc = b;
        r.lanes[0] = 4'(l0);
        r.lanes[1] = 4'(l1);
        r.lanes[2] = 4'(l2);
        r.lanes[3] = 4'(l3);
        r.ptr = 3'(p);
        return r;
    endfunction

    // Expected lane contents, captured before the edge
    logic [3:0] e_bc;
    logic [PR_W-1:0] e_pr [4];
    logic [AR_W-1:0] e_ar [4];
    logic [2:0] e_ptr;

    task automatic chk_bus(input string name);
        chk({name, "_bc"}, 64'(cdb_broadcast), 64'(e_bc));
        chk({name, "_ptr"}, 64'(rr_ptr), 64'(e_ptr));
        chk({name, "_pr"}, 64'({pr3, pr2, pr1, pr0}),
            64'({e_pr[3], e_pr[2], e_pr[1], e_pr[0]}));
        chk({name, "_ar"}, 64'({ar3, ar2, ar1, ar0}),
            64'({e_ar[3], e_ar[2], e_ar[1], e_ar[0]}));
    endtask

    // Reference model: list valid requesters in scan order, take four
    int m_ptr;
    int m_k;
    int m_lane [4];
    logic [N-1:0] m_g;

    task automatic model_step(input logic [N-1:0] v, input logic f);
        int q[$];
        m_g = '0;
        if (!f)
            for (int j = 0; j < N; j++)
                if (v[(m_ptr + j) % N]) q.push_back((m_ptr + j) % N);
        m_k = (q.size() < 4) ? q.size() : 4;
        for (int l = 0; l < 4; l++) m_lane[l] = (l < m_k) ? q[l] : 0;
        for (int l = 0; l < m_k; l++) m_g[q[l]] = 1'b1;
        e_bc = 4'((1 << m_k) - 1);
        for (int l = 0; l < 4; l++) begin
            e_pr[l] = (l < m_k) ? tpr[m_lane[l]] : '0;
            e_ar[l] = (l < m_k) ? tar[m_lane[l]] : '0;
        end
        if (m_k > 0) m_ptr = (q[m_k-1] + 1) % N;
        e_ptr = 3'(m_ptr);
    endtask

    vec_t vt [14];
    int wt [N];
    logic [N-1:0] g_seen;

    initial begin
        for (int i = 0; i < N; i++) begin
            tpr[i] = PR_W'(9 * i + 3);
            tar[i] = AR_W'(3 * i + 1);
        end
        vt[0]  = mk(8'h08, 0, 8'h08, 4'b0001, 3, 0, 0, 0, 4);
        vt[1]  = mk(8'hFF, 0, 8'hF0, 4'b1111, 4, 5, 6, 7, 0);
        vt[2]  = mk(8'hFF, 0, 8'h0F, 4'b1111, 0, 1, 2, 3, 4);
        vt[3]  = mk(8'h30, 0, 8'h30, 4'b0011, 4, 5, 0, 0, 6);
        vt[4]  = mk(8'hC7, 0, 8'hC3, 4'b1111, 6, 7, 0, 1, 2);
        vt[5]  = mk(8'h05, 0, 8'h05, 4'b0011, 2, 0, 0, 0, 1);
        vt[6]  = mk(8'hFF, 1, 8'h00, 4'b0000, 0, 0, 0, 0, 1);
        vt[7]  = mk(8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 1);
        vt[8]  = mk(8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 1);
        vt[9]  = mk(8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 1);
        vt[10] = mk(8'hFF, 0, 8'h1E, 4'b1111, 1, 2, 3, 4, 5);
        vt[11] = mk(8'h81, 0, 8'h81, 4'b0011, 7, 0, 0, 0, 1);
        vt[12] = mk(8'h20, 0, 8'h20, 4'b0001, 5, 0, 0, 0, 6);
        vt[13] = mk(8'h7F, 0, 8'h47, 4'b1111, 6, 0, 1, 2, 3);

        // Power-on reset with requests pending
        req_valid = '1;
        #2 reset = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) begin
            e_pr[l] = '0;
            e_ar[l] = '0;
        end
        e_bc = '0;
        e_ptr = '0;
        chk_bus("por");
        chk("por_grant", 64'(req_grant), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (vt[n]) begin
            req_valid = vt[n].valid;
            flush = vt[n].flush;
            #1;
            chk($sformatf("vec%0d_grant", n), 64'(req_grant),
                64'(vt[n].grant));
            e_bc = vt[n].bc;
            e_ptr = vt[n].ptr;
            for (int l = 0; l < 4; l++) begin
                e_pr[l] = vt[n].bc[l] ? tpr[vt[n].lanes[l]] : '0;
                e_ar[l] = vt[n].bc[l] ? tar[vt[n].lanes[l]] : '0;
            end
            @(posedge clock);
            #1;
            chk_bus($sformatf("vec%0d", n));
            @(negedge clock);
        end
        flush = 1'b0;

        // Reset dropped between edges while the bus is full
        req_valid = '1;
        @(posedge clock);
        #1;
        chk("pre_rst_bc", 64'(cdb_broadcast), 64'hF);
        #2 reset = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) begin
            e_pr[l] = '0;
            e_ar[l] = '0;
        end
        e_bc = '0;
        e_ptr = '0;
        chk_bus("mid_rst");
        chk("mid_rst_grant", 64'(req_grant), 64'd0);
        flush = 1'b1;
        @(posedge clock);
        #1;
        chk_bus("rst_flush");
        chk("rst_hold_grant", 64'(req_grant), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        flush = 1'b0;
        req_valid = 8'h01;
        #1;
        chk("post_rst_grant", 64'(req_grant), 64'h01);
        @(posedge clock);
        #1;
        chk("post_rst_ptr", 64'(rr_ptr), 64'd1);
        chk("post_rst_bc", 64'(cdb_broadcast), 64'h1);

        // Randomized requesters obeying the valid/grant handshake
        m_ptr = 1;
        req_valid = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    tpr[i] = PR_W'($urandom);
                    tar[i] = AR_W'($urandom);
                end
            flush = ($urandom_range(0, 9) == 0);
            #1;
            model_step(req_valid, flush);
            chk("rnd_grant", 64'(req_grant), 64'(m_g));
            g_seen = req_grant;
            for (int i = 0; i < N; i++) begin
                if (flush || !req_valid[i] || g_seen[i]) wt[i] = 0;
                else wt[i]++;
                if (wt[i] > 0)
                    chk("rnd_fair", 64'(wt[i] > 1), 64'd0);
            end
            @(posedge clock);
            #1;
            chk_bus("rnd");
            req_valid = req_valid & ~m_g;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
